data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Responder for the core's data-memory port: accepts read and write requests and serves them from an internal word-wide synchronous RAM.
- Adds what the core's current fixed-timing port lacks: byte/halfword/word access sizes, sign/zero extension, little-endian lane placement, misalignment and range error reporting, and explicit completion strobes (r_valid, w_done).
- Sub-word stores run as a read-modify-write sequence, because the RAM has no byte enables.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the RAM; must be a power of two.
- ADDR_BASE, 32'h0000_0000: byte address mapped to RAM word 0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- r_en  in  1  read request; sampled only when busy=0.
- r_addr  in  32  read byte address.
- r_size  in  3  read size/extension, RV32I load funct3 encoding.
- r_data  out  32  formatted, extended read data.
- r_valid  out  1  one-cycle pulse: r_data is valid.
- w_en  in  1  write request; sampled only when busy=0.
- w_addr  in  32  write byte address.
- w_data  in  32  store data; low byte/half used for sub-word stores.
- w_size  in  3  store size, RV32I store funct3 encoding.
- w_done  out  1  one-cycle pulse: write completed or rejected.
- busy  out  1  high while a request is in progress; new requests ignored.
- err  out  1  one-cycle pulse alongside r_valid/w_done: request rejected.

Behaviour:
- Reset: r_data=0, r_valid=0, w_done=0, busy=0, err=0, state=IDLE. RAM contents are not cleared.
- Address decode:
  - off = addr - ADDR_BASE; word index = off[31:2]; lane = off[1:0].
  - Out of range when off[31:2] >= DEPTH_WORDS.
- Misalignment: half with lane[0]=1; word with lane!=0. Misaligned or out-of-range requests touch no RAM and complete with err=1.
- Valid sizes:
  - Read: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Write: 000 SB, 001 SH, 010 SW.
  - Any other code completes with err=1.
- Simultaneous r_en and w_en in IDLE: neither access is performed; r_valid, w_done and err all pulse at N+1.
- States and transitions (request accepted at edge N):
  - IDLE: on r_en, issue RAM read and go to RD_RESP. On SW, write RAM at N and go to WR_RESP. On SB/SH, issue RAM read and go to RMW_WR. On error, go to ERR_RESP.
  - RD_RESP (cycle N+1): r_data = selected lane, sign- or zero-extended; r_valid=1 for one cycle; return to IDLE.
  - WR_RESP (N+1): w_done=1; return to IDLE.
  - RMW_WR (N+1): merge the lane bytes into the read word and write RAM; go to WR_RESP, so w_done pulses at N+2.
  - ERR_RESP (N+1): err=1 plus r_valid or w_done (r_data=0 on reads); return to IDLE.
- busy: high in every state except IDLE.
- Latency from the accept edge:
  - Reads: r_valid at N+1.
  - SW and rejected requests: w_done at N+1.
  - SB/SH: w_done at N+2.
- Requests arriving while busy=1 are dropped with no response. The initiator waits for r_valid/w_done before issuing the next request.
- r_data holds its value until the next read response.
- Little-endian: byte k of a word is bits [8k+7:8k].
- Reset mid-operation: the state machine returns to IDLE. A pending RMW write is not performed, even when reset coincides with the RMW_WR edge. No strobes are emitted.

Decomposition:
- Shared package dmem_pkg:
  - size encodings (MEM_SZ_B/H/W/BU/HU);
  - state encodings (DM_IDLE, DM_RD_RESP, DM_WR_RESP, DM_RMW_WR, DM_ERR_RESP);
  - alignment-check function.
- One combinational sub-module, mem_lane_fmt:
  - load path: word, lane, size -> extended data;
  - store path: old word, new data, lane, size -> merged word.

Test Plan:
- SW 0x8765_4321 to 0x10, then LW 0x10 -> w_done at N+1, r_valid at N+1, r_data=0x8765_4321, err=0.
- After the SW above, LB 0x13 -> 0xFFFF_FF87; LBU 0x13 -> 0x0000_0087; LH 0x12 -> 0xFFFF_8765; LHU 0x10 -> 0x0000_4321.
- SB 0xAA to 0x11, then LW 0x10 -> busy for 2 cycles, w_done at N+2, r_data=0x8765_AA21.
- LW 0x12, SH 0x13, and LW at ADDR_BASE+4*DEPTH_WORDS -> err=1 with the matching strobe at N+1; RAM unchanged; r_data=0.
- Assert rst at the RMW_WR edge of SB 0x55 to 0x10 -> no w_done; busy=0 the next cycle; LW 0x10 returns the pre-store word.
- r_en and w_en both high -> r_valid, w_done and err pulse together; RAM unchanged. A second request issued while busy -> ignored, no extra strobe.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_pkg;

  // RV32I load/store funct3 size codes
  localparam logic [2:0] MEM_SZ_B  = 3'b000;
  localparam logic [2:0] MEM_SZ_H  = 3'b001;
  localparam logic [2:0] MEM_SZ_W  = 3'b010;
  localparam logic [2:0] MEM_SZ_BU = 3'b100;
  localparam logic [2:0] MEM_SZ_HU = 3'b101;

  typedef enum logic [2:0] {
    DM_IDLE,
    DM_RD_RESP,
    DM_WR_RESP,
    DM_RMW_WR,
    DM_ERR_RESP
  } dm_state_t;

  typedef struct packed {
    logic [1:0]  lane;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err_rd;
    logic        err_wr;
  } dm_req_t;

  function automatic logic lane_aligned(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      MEM_SZ_H, MEM_SZ_HU: return !lane[0];
      MEM_SZ_W:            return lane == 2'b00;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic rd_size_ok(input logic [2:0] size);
    return size inside {MEM_SZ_B, MEM_SZ_H, MEM_SZ_W, MEM_SZ_BU, MEM_SZ_HU};
  endfunction

  function automatic logic wr_size_ok(input logic [2:0] size);
    return size inside {MEM_SZ_B, MEM_SZ_H, MEM_SZ_W};
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Lane steering: extracts/extends load data and merges sub-word store data
// into an existing word (little-endian, byte k at bits [8k+7:8k]).
module mem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  lane,
  input  logic [2:0]  size,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  be;

  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (size)
      MEM_SZ_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_SZ_H:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_SZ_BU: ld_data = {24'h0, ld_byte};
      MEM_SZ_HU: ld_data = {16'h0, ld_half};
      default:   ld_data = rd_word;
    endcase
  end

  always_comb begin
    case (size)
      MEM_SZ_B: be = 4'b0001 << lane;
      MEM_SZ_H: be = lane[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
  end

  // Bytes are replicated across the word so each lane picks its source locally
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] src;
    assign src = (size == MEM_SZ_B) ? new_data[7:0] :
                 (size == MEM_SZ_H) ? new_data[8*(k%2) +: 8] :
                                      new_data[8*k +: 8];
    assign st_word[8*k +: 8] = be[k] ? src : rd_word[8*k +: 8];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: sized loads/stores against a word-wide synchronous RAM,
// with read-modify-write for sub-word stores and error completion for bad requests.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_en,
  input  logic [31:0] r_addr,
  input  logic [2:0]  r_size,
  output logic [31:0] r_data,
  output logic        r_valid,
  input  logic        w_en,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  input  logic [2:0]  w_size,
  output logic        w_done,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dm_state_t     state, state_nxt;
  dm_req_t       req;
  logic [AW-1:0] req_idx;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q, ram_wd;
  logic [AW-1:0] ram_addr;
  logic          ram_re, ram_we;

  logic [31:0]   r_off, w_off;
  logic          r_bad, w_bad;
  logic [31:0]   ld_data, st_word, r_data_q;

  assign r_off = r_addr - ADDR_BASE;
  assign w_off = w_addr - ADDR_BASE;
  assign r_bad = (r_off[31:2] >= 30'(DEPTH_WORDS)) || !lane_aligned(r_size, r_off[1:0]) ||
                 !rd_size_ok(r_size);
  assign w_bad = (w_off[31:2] >= 30'(DEPTH_WORDS)) || !lane_aligned(w_size, w_off[1:0]) ||
                 !wr_size_ok(w_size);

  mem_lane_fmt u_fmt (
    .rd_word  (ram_q),
    .new_data (req.wdata),
    .lane     (req.lane),
    .size     (req.size),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= DM_IDLE;
    else     state <= state_nxt;
  end

  // Request fields are only consumed after leaving IDLE, so no reset needed
  always_ff @(posedge clk) begin
    if (state == DM_IDLE) begin
      req <= '{lane:   r_en ? r_off[1:0] : w_off[1:0],
               size:   r_en ? r_size : w_size,
               wdata:  w_data,
               err_rd: r_en && (w_en || r_bad),
               err_wr: w_en && (r_en || w_bad)};
      req_idx <= r_en ? r_off[AW+1:2] : w_off[AW+1:2];
    end
  end

  always_comb begin
    state_nxt = state;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_idx;
    ram_wd    = st_word;
    case (state)
      DM_IDLE: begin
        if (r_en && w_en) begin
          state_nxt = DM_ERR_RESP;
        end else if (r_en) begin
          if (r_bad) begin
            state_nxt = DM_ERR_RESP;
          end else begin
            ram_re    = 1'b1;
            ram_addr  = r_off[AW+1:2];
            state_nxt = DM_RD_RESP;
          end
        end else if (w_en) begin
          if (w_bad) begin
            state_nxt = DM_ERR_RESP;
          end else if (w_size == MEM_SZ_W) begin
            ram_we    = 1'b1;
            ram_addr  = w_off[AW+1:2];
            ram_wd    = w_data;
            state_nxt = DM_WR_RESP;
          end else begin
            ram_re    = 1'b1;
            ram_addr  = w_off[AW+1:2];
            state_nxt = DM_RMW_WR;
          end
        end
      end
      DM_RMW_WR: begin
        ram_we    = 1'b1;
        state_nxt = DM_WR_RESP;
      end
      default: state_nxt = DM_IDLE;
    endcase
  end

  // Write is suppressed under reset so an interrupted RMW leaves the word intact
  always_ff @(posedge clk) begin
    if (ram_we && !rst) mem[ram_addr] <= ram_wd;
    if (ram_re)         ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst)                                         r_data_q <= 32'h0;
    else if (state == DM_RD_RESP)                    r_data_q <= ld_data;
    else if (state == DM_ERR_RESP && req.err_rd)     r_data_q <= 32'h0;
  end

  assign busy    = state != DM_IDLE;
  assign err     = state == DM_ERR_RESP;
  assign r_valid = (state == DM_RD_RESP) || (err && req.err_rd);
  assign w_done  = (state == DM_WR_RESP) || (err && req.err_wr);
  assign r_data  = (state == DM_RD_RESP) ? ld_data : (r_valid ? 32'h0 : r_data_q);

endmodule
